// File: rtl/ita_fifo_reader.sv
// ita_fifo_reader
//   Drains one tile of TileBeats words from a first-word-fall-through FIFO
//   and presents them as a valid/ready stream. A 2-entry skid buffer keeps
//   the FIFO pop decision independent of oup_ready_i, so full throughput is
//   kept without a combinational ready->pop path.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          one-cycle pulse, starts a tile (only honoured in IDLE)
//   fifo_empty_i     FIFO empty flag
//   data_from_fifo_i FIFO head word, valid while fifo_empty_i=0
//   pop_from_fifo_o  consumes the FIFO head this cycle
//   oup_valid_o      output beat valid
//   oup_ready_i      downstream ready
//   oup_data_o       output beat data
//   oup_last_o       final beat of the tile (qualified by oup_valid_o)
//   busy_o           state is not IDLE
//   done_o           one-cycle pulse after the last beat was accepted
module ita_fifo_reader #(
  parameter type         fifo_data_t = logic [31:0],
  parameter int unsigned FifoWidth   = $bits(fifo_data_t),
  parameter int unsigned TileBeats   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 fifo_empty_i,
  input  logic [FifoWidth-1:0] data_from_fifo_i,
  output logic                 pop_from_fifo_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic [FifoWidth-1:0] oup_data_o,
  output logic                 oup_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned     CntW    = $clog2(TileBeats + 1);
  localparam logic [CntW-1:0] TileCnt = CntW'(TileBeats);
  localparam logic [CntW-1:0] LastIdx = CntW'(TileBeats - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [1:0]           count_q;
  logic [CntW-1:0]      pop_cnt_q;
  logic [CntW-1:0]      send_cnt_q;
  logic [FifoWidth-1:0] buf_q [2];

  logic pop;
  logic hs;

  // Pops stop once the whole tile is fetched, leaving the next tile's words
  // in the FIFO. count_q<2 guarantees a free buffer slot at the next edge.
  assign pop = (state_q == RUN) && !fifo_empty_i &&
               (pop_cnt_q < TileCnt) && (count_q < 2'd2);
  assign hs  = oup_valid_o && oup_ready_i;

  assign pop_from_fifo_o = pop;
  assign oup_valid_o     = (count_q != 2'd0);
  assign oup_data_o      = buf_q[0];
  assign oup_last_o      = oup_valid_o && (send_cnt_q == LastIdx);
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  // Control FSM with tile counters. Counters cannot pass TileBeats: pops are
  // gated at TileCnt and every send consumes an earlier pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pop_cnt_q  <= '0;
      send_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            pop_cnt_q  <= '0;
            send_cnt_q <= '0;
          end
        end
        RUN: begin
          if (pop) pop_cnt_q <= pop_cnt_q + CntW'(1);
          if (hs)  send_cnt_q <= send_cnt_q + CntW'(1);
          if (hs && (send_cnt_q == LastIdx)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer, buf_q[0] is the head. A pop with a concurrent
  // handshake shifts the head out and appends the new word behind it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      case ({pop, hs})
        2'b10: begin
          if (count_q == 2'd0) buf_q[0] <= data_from_fifo_i;
          else                 buf_q[1] <= data_from_fifo_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf_q[0] <= data_from_fifo_i;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= data_from_fifo_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/ita_fifo_reader.md
ITA_FIFO_READER -- requirements
Module: ita_fifo_reader

Interface
REQ-001 Parameter FifoWidth, default $bits(fifo_data_t), width in bits of one FIFO word and one output beat.
REQ-002 Parameter TileBeats, default 16, number of beats per tile; must be >= 1.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle pulse that starts draining one tile.
REQ-006 fifo_empty_i  input  1  FIFO empty flag.
REQ-007 data_from_fifo_i  input  FifoWidth  FIFO head word (first-word-fall-through), valid whenever fifo_empty_i=0.
REQ-008 pop_from_fifo_o  output  1  consumes the FIFO head in the same cycle.
REQ-009 oup_valid_o  output  1  output beat valid.
REQ-010 oup_ready_i  input  1  downstream ready.
REQ-011 oup_data_o  output  FifoWidth  output beat data.
REQ-012 oup_last_o  output  1  marks the final beat of the tile; qualified by oup_valid_o.
REQ-013 busy_o  output  1  high when the state is not IDLE.
REQ-014 done_o  output  1  one-cycle pulse after the last beat of the tile is accepted.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE.
REQ-016 IDLE->RUN SHALL occur on start_i=1; start_i SHALL be ignored in RUN and DONE.
REQ-017 RUN->DONE SHALL occur in the cycle in which the handshake of the beat with send_cnt=TileBeats-1 completes.
REQ-018 DONE->IDLE SHALL occur unconditionally after one cycle, with done_o=1 only during DONE.
REQ-019 The block SHALL hold a 2-entry output buffer in FIFO order; oup_valid_o SHALL equal (count>0), and oup_data_o SHALL equal the buffer head, driven from registers.
REQ-020 pop_from_fifo_o SHALL equal (state==RUN && !fifo_empty_i && pop_cnt<TileBeats && count<2), decoded combinationally.
REQ-021 A pop SHALL write data_from_fifo_i into the buffer tail at the next edge and increment pop_cnt.
REQ-022 A handshake (oup_valid_o && oup_ready_i) SHALL remove the buffer head and increment send_cnt.
REQ-023 A simultaneous pop and handshake SHALL leave count unchanged and preserve beat order.
REQ-024 pop_cnt and send_cnt SHALL be $clog2(TileBeats+1) bits wide, SHALL saturate at TileBeats by construction, and SHALL clear on the IDLE->RUN transition.
REQ-025 oup_last_o SHALL equal (oup_valid_o && send_cnt==TileBeats-1).
REQ-026 With oup_ready_i held high and the FIFO never empty, the block SHALL sustain 1 beat/cycle, with first oup_valid_o one cycle after the first pop.
REQ-027 oup_data_o and oup_last_o SHALL remain stable while oup_valid_o=1 and oup_ready_i=0.
REQ-028 No pop SHALL occur when pop_cnt reaches TileBeats, so words of the next tile remain in the FIFO.
REQ-029 fifo_empty_i=1 SHALL stall popping only; already buffered beats SHALL still drain.
REQ-030 The block SHALL NOT pop or assert oup_valid_o in IDLE or DONE (the buffer is empty by construction there).

Reset
REQ-031 During rst_ni=0 the block SHALL force state=IDLE, count=0, pop_cnt=0 and send_cnt=0.
REQ-032 During rst_ni=0 the outputs SHALL be pop_from_fifo_o=0, oup_valid_o=0, oup_last_o=0, busy_o=0, done_o=0 and oup_data_o='0.
REQ-033 Reset asserted mid-tile SHALL discard buffered beats and SHALL NOT produce done_o; after release the block SHALL wait for a new start_i.

Verification
REQ-034 TileBeats=4, FIFO preloaded 0xA1..0xA4, ready=1, start at cycle 0 -> pops in cycles 1-4; valid beats 0xA1..0xA4 in cycles 2-5; last in cycle 5; done in cycle 6; busy 1->0 in cycle 7.
REQ-035 Same stimulus with ready=0 for cycles 2-6 -> pops only in cycles 1-2 (buffer full); 0xA1 held stable; all 4 beats delivered in order; done once.
REQ-036 FIFO empty in cycles 2-3 mid-tile -> no pop while empty; buffered beat still delivered; tile completes with exactly 4 beats.
REQ-037 FIFO holds 6 words, TileBeats=4 -> exactly 4 pops; 2 words remain (fifo_empty_i stays 0); second start drains words 5-6 plus later words.
REQ-038 start_i pulsed during RUN and DONE -> ignored; beat count unaffected.
REQ-039 rst_ni low after 2 beats -> outputs reset immediately; no done_o; new start drains a full 4 beats.
